// File: rtl/qam_slicer_mer.sv
// Per-rail 16QAM decision slicer with block-averaged squared error for MER,
// plus the block-boundary strobe that frames the reference level averager.
module qam_slicer_mer #(
    parameter int MAX_LOG2 = 20,
    parameter int DATA_W   = 18
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sym_clk_ena,
    input  logic signed [DATA_W-1:0]   decision_variable,
    input  logic signed [DATA_W-1:0]   reference_level,
    input  logic        [4:0]          log2_symbols,
    output logic        [1:0]          symbol_out,
    output logic signed [DATA_W-1:0]   ideal_level,
    output logic signed [DATA_W:0]     slicer_error,
    output logic        [2*DATA_W+2:0] error_power,
    output logic                       power_valid,
    output logic                       clear_accumulator
);
    localparam int ERR_W = DATA_W + 1;
    localparam int SQ_W  = 2 * ERR_W;
    localparam int PWR_W = SQ_W + 1;
    localparam int ACC_W = SQ_W + MAX_LOG2;
    localparam int CNT_W = MAX_LOG2;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                    state_q, state_d;
    logic        [1:0]         symbol_q, symbol_d;
    logic signed [DATA_W-1:0]  ideal_q, ideal_d;
    logic signed [ERR_W-1:0]   error_q, error_d;
    logic        [PWR_W-1:0]   power_q, power_d;
    logic                      powerValid_q, powerValid_d;
    logic                      clear_q, clear_d;
    logic                      errValid_q, errValid_d;
    logic        [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   count_q, count_d;
    logic        [4:0]         nLat_q, nLat_d;

    logic signed [ERR_W-1:0]   dvExt, refExt, halfRef, idealNext;
    logic        [1:0]         symbolNext;
    logic signed [SQ_W-1:0]    errWide;
    logic        [SQ_W-1:0]    square;
    logic        [ACC_W-1:0]   sumNext, sumShifted;
    logic        [CNT_W:0]     blockLen;
    logic        [CNT_W-1:0]   lastCount;
    logic        [4:0]         nClamped;

    // Thresholds sit at 0 and +/-ref; ideal levels at +/-ref/2 and +/-3ref/2.
    always_comb begin
        dvExt   = {decision_variable[DATA_W-1], decision_variable};
        refExt  = {reference_level[DATA_W-1], reference_level};
        halfRef = refExt >>> 1;
        if (dvExt >= refExt) begin
            symbolNext = 2'b10;
            idealNext  = refExt + halfRef;
        end else if (!dvExt[ERR_W-1]) begin
            symbolNext = 2'b11;
            idealNext  = halfRef;
        end else if (dvExt >= -refExt) begin
            symbolNext = 2'b01;
            idealNext  = -halfRef;
        end else begin
            symbolNext = 2'b00;
            idealNext  = -(refExt + halfRef);
        end
    end

    assign errWide    = {{(SQ_W-ERR_W){error_q[ERR_W-1]}}, error_q};
    assign square     = errWide * errWide;
    assign sumNext    = acc_q + {{(ACC_W-SQ_W){1'b0}}, square};
    assign sumShifted = sumNext >> nLat_q;
    assign blockLen   = (CNT_W+1)'(1) << nLat_q;
    assign lastCount  = blockLen[CNT_W-1:0] - CNT_W'(1);
    assign nClamped   = (log2_symbols == 5'd0)            ? 5'd1 :
                        (log2_symbols > 5'(MAX_LOG2))     ? 5'(MAX_LOG2) :
                        log2_symbols;

    // Accumulation consumes the error registered on the previous enable, so the
    // first enable after reset only primes the slicer register.
    always_comb begin
        state_d      = state_q;
        symbol_d     = symbol_q;
        ideal_d      = ideal_q;
        error_d      = error_q;
        power_d      = power_q;
        powerValid_d = 1'b0;
        clear_d      = clear_q;
        errValid_d   = errValid_q;
        acc_d        = acc_q;
        count_d      = count_q;
        nLat_d       = nLat_q;
        if (sym_clk_ena) begin
            symbol_d   = symbolNext;
            ideal_d    = idealNext[DATA_W-1:0];
            error_d    = dvExt - idealNext;
            errValid_d = 1'b1;
            clear_d    = 1'b0;
            if (errValid_q) begin
                case (state_q)
                    IDLE: begin
                        state_d = ACCUM;
                        nLat_d  = nClamped;
                        acc_d   = {{(ACC_W-SQ_W){1'b0}}, square};
                        count_d = CNT_W'(1);
                    end
                    ACCUM: begin
                        if (count_q == lastCount) begin
                            power_d      = sumShifted[PWR_W-1:0];
                            powerValid_d = 1'b1;
                            acc_d        = '0;
                            count_d      = '0;
                            nLat_d       = nClamped;
                            clear_d      = 1'b1;
                        end else begin
                            acc_d   = sumNext;
                            count_d = count_q + CNT_W'(1);
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            symbol_q     <= 2'b00;
            ideal_q      <= '0;
            error_q      <= '0;
            power_q      <= '0;
            powerValid_q <= 1'b0;
            clear_q      <= 1'b0;
            errValid_q   <= 1'b0;
            acc_q        <= '0;
            count_q      <= '0;
            nLat_q       <= '0;
        end else begin
            state_q      <= state_d;
            symbol_q     <= symbol_d;
            ideal_q      <= ideal_d;
            error_q      <= error_d;
            power_q      <= power_d;
            powerValid_q <= powerValid_d;
            clear_q      <= clear_d;
            errValid_q   <= errValid_d;
            acc_q        <= acc_d;
            count_q      <= count_d;
            nLat_q       <= nLat_d;
        end
    end

    assign symbol_out        = symbol_q;
    assign ideal_level       = ideal_q;
    assign slicer_error      = error_q;
    assign error_power       = power_q;
    assign power_valid       = powerValid_q;
    assign clear_accumulator = clear_q;

endmodule

// File: tb/tb_qam_slicer_mer.sv
// Scoreboard bench for qam_slicer_mer: slicer decisions checked per enable,
// block powers queued by a reference model and popped on each power_valid pulse.
`timescale 1ns/1ps
module tb_qam_slicer_mer;

    logic               clk = 1'b0;
    logic               reset;
    logic               symClkEna;
    logic signed [17:0] decisionVariable;
    logic signed [17:0] referenceLevel;
    logic        [4:0]  log2Symbols;
    logic        [1:0]  symbolOut;
    logic signed [17:0] idealLevel;
    logic signed [18:0] slicerError;
    logic        [38:0] errorPower;
    logic               powerValid;
    logic               clearAccumulator;

    int testsRun    = 0;
    int testsFailed = 0;

    longint expPower[$];
    bit     mValid, mActive, mClear;
    int     mCount, mN;
    longint mAcc, mLastErr;

    qam_slicer_mer dut (
        .clk               (clk),
        .reset             (reset),
        .sym_clk_ena       (symClkEna),
        .decision_variable (decisionVariable),
        .reference_level   (referenceLevel),
        .log2_symbols      (log2Symbols),
        .symbol_out        (symbolOut),
        .ideal_level       (idealLevel),
        .slicer_error      (slicerError),
        .error_power       (errorPower),
        .power_valid       (powerValid),
        .clear_accumulator (clearAccumulator)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    function automatic int clampN(input int n);
        if (n < 1) return 1;
        if (n > 20) return 20;
        return n;
    endfunction

    function automatic void expectedSlice(input int dv, input int r, output int sym, output int ideal);
        int h;
        h = r >>> 1;
        if (dv >= r) begin
            sym = 2; ideal = r + h;
        end else if (dv >= 0) begin
            sym = 3; ideal = h;
        end else if (dv >= -r) begin
            sym = 1; ideal = -h;
        end else begin
            sym = 0; ideal = -(r + h);
        end
    endfunction

    // Power results are popped whenever the DUT pulses power_valid.
    always @(negedge clk) begin
        if (powerValid === 1'b1) begin
            if (expPower.size() == 0)
                checkOutput("unexpected_power_valid", 64'(powerValid), 64'd0);
            else
                checkOutput("error_power", 64'(errorPower), expPower.pop_front());
        end
    end

    task automatic modelReset();
        mValid = 1'b0; mActive = 1'b0; mClear = 1'b0;
        mCount = 0; mN = 0; mAcc = 0; mLastErr = 0;
        expPower.delete();
    endtask

    task automatic checkResetState();
        checkOutput("rst_symbol", 64'(symbolOut), 64'd0);
        checkOutput("rst_ideal", 64'(idealLevel), 64'd0);
        checkOutput("rst_error", 64'(slicerError), 64'd0);
        checkOutput("rst_power", 64'(errorPower), 64'd0);
        checkOutput("rst_power_valid", 64'(powerValid), 64'd0);
        checkOutput("rst_clear", 64'(clearAccumulator), 64'd0);
    endtask

    task automatic midReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkResetState();
        modelReset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic applyStimulus(input int dv, input int refLvl, input int nLog, input int gap);
        int     expSym, expIdeal;
        longint sq;
        bit     closeBlock;
        @(negedge clk);
        decisionVariable = 18'(dv);
        referenceLevel   = 18'(refLvl);
        log2Symbols      = 5'(nLog);
        symClkEna        = 1'b1;
        #1;
        checkOutput("clear_before_ena", 64'(clearAccumulator), 64'(mClear));
        @(posedge clk);
        #1;
        symClkEna = 1'b0;
        expectedSlice(dv, refLvl, expSym, expIdeal);
        closeBlock = 1'b0;
        if (mValid) begin
            sq = mLastErr * mLastErr;
            if (!mActive) begin
                mActive = 1'b1;
                mN      = clampN(nLog);
                mAcc    = sq;
                mCount  = 1;
            end else if (mCount == (1 << mN) - 1) begin
                expPower.push_back((mAcc + sq) >> mN);
                closeBlock = 1'b1;
                mN     = clampN(nLog);
                mAcc   = 0;
                mCount = 0;
            end else begin
                mAcc   = mAcc + sq;
                mCount = mCount + 1;
            end
        end
        mValid   = 1'b1;
        mClear   = closeBlock;
        mLastErr = dv - expIdeal;
        checkOutput("symbol_out", 64'(symbolOut), 64'(expSym));
        checkOutput("ideal_level", 64'(idealLevel), 64'(expIdeal));
        checkOutput("slicer_error", 64'(slicerError), mLastErr);
        checkOutput("power_valid", 64'(powerValid), 64'(closeBlock));
        checkOutput("clear_after_ena", 64'(clearAccumulator), 64'(closeBlock));
        repeat (gap) @(posedge clk);
    endtask

    initial begin
        reset            = 1'b1;
        symClkEna        = 1'b0;
        decisionVariable = '0;
        referenceLevel   = '0;
        log2Symbols      = 5'd2;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkResetState();
        @(negedge clk);
        reset = 1'b0;

        // Single decisions in every region
        applyStimulus(49152, 32768, 2, 3);
        applyStimulus(20000, 32768, 2, 3);
        applyStimulus(-32768, 32768, 2, 3);
        applyStimulus(-40000, 32768, 2, 3);

        // Constant error, N=2, enables every 4 clk
        for (int i = 0; i < 12; i++)
            applyStimulus(20000, 32768, 2, 3);
        checkOutput("const_block_power", 64'(errorPower), 64'd13075456);

        // N=3 block: seven zero errors and one 8192
        midReset();
        for (int i = 0; i < 7; i++)
            applyStimulus(16384, 32768, 3, 1);
        applyStimulus(24576, 32768, 3, 1);
        applyStimulus(16384, 32768, 3, 1);
        checkOutput("n3_block_power", 64'(errorPower), 64'd8388608);

        // log2_symbols changes mid-block; next block spans 16
        midReset();
        applyStimulus(-8000, 32768, 2, 1);
        applyStimulus(-7000, 32768, 2, 1);
        for (int i = 0; i < 19; i++)
            applyStimulus(1000 * i - 6000, 32768, 4, 1);
        applyStimulus(30000, 32768, 2, 1);
        applyStimulus(-30000, 32768, 2, 1);

        // Reset at count=2, then random traffic with log2=0 clamped to 1
        midReset();
        for (int i = 0; i < 16; i++) begin
            int dv, r;
            dv = int'($urandom_range(262143)) - 131072;
            r  = (i % 4 == 0) ? 0 : int'($urandom_range(60000));
            applyStimulus(dv, r, 0, int'($urandom_range(2)));
        end
        repeat (3) @(posedge clk);

        checkOutput("scoreboard_empty", 64'(expPower.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
